// File: rtl/spc_ctl.sv
// Stack-pointer controller for the 32x19 SPC stack RAM.
// Turns CPU push/pop/replace requests into RAM cycles, shares the RAM with
// the spy/debug bus, tracks stack depth and keeps sticky overflow/underflow.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | accepts CPU ops (push completes here), grants spy requests
// S_POP_RD   | pop read data returns; pointer/depth step down
// S_REPL_RD  | replace: old top returns from RAM
// S_REPL_WR  | replace: latched data written to the top entry
// S_SPY_RD   | spy read data returns from RAM
// S_SPY_DONE | spy_ack pulse, back to idle
module spc_ctl #(
    parameter int AW     = 5,
    parameter int DW     = 19,
    parameter int STARVE = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_push,
    input  logic          cpu_pop,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          spy_req,
    input  logic          spy_we,
    input  logic          spy_ptr_we,
    input  logic          spy_clr,
    input  logic [AW-1:0] spy_addr,
    input  logic [DW-1:0] spy_wdata,
    output logic          spy_ack,
    output logic [DW-1:0] spy_rdata,
    output logic [AW-1:0] mem_raddr,
    output logic          mem_rden,
    input  logic [DW-1:0] mem_q,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_wren,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] spcptr,
    output logic [AW:0]   depth,
    output logic          ovf,
    output logic          unf
);

    localparam int SCW = $clog2(STARVE + 1);
    localparam logic [SCW-1:0] STARVE_C = SCW'(STARVE);
    localparam logic [SCW-1:0] SC_ONE   = SCW'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    DEP_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]    FULL     = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_POP_RD   = 3'd1,
        S_REPL_RD  = 3'd2,
        S_REPL_WR  = 3'd3,
        S_SPY_RD   = 3'd4,
        S_SPY_DONE = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  spcptr_q, spcptr_d;
    logic [AW:0]    depth_q, depth_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic [DW-1:0]  wbuf_q, wbuf_d;
    logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic           cpu_rvalid_q, cpu_rvalid_d;
    logic [DW-1:0]  spy_rdata_q, spy_rdata_d;
    logic           ovf_set, unf_set;
    logic           spy_grant, spy_busy;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            spcptr_q     <= '0;
            depth_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            starve_q     <= '0;
            wbuf_q       <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            spy_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            spcptr_q     <= spcptr_d;
            depth_q      <= depth_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            starve_q     <= starve_d;
            wbuf_q       <= wbuf_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            spy_rdata_q  <= spy_rdata_d;
        end
    end

    // Next state, RAM strobes, pointer/depth/flag updates and spy arbitration.
    always_comb begin
        state_d      = state_q;
        spcptr_d     = spcptr_q;
        depth_d      = depth_q;
        wbuf_d       = wbuf_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_rvalid_d = 1'b0;
        spy_rdata_d  = spy_rdata_q;
        ovf_set      = 1'b0;
        unf_set      = 1'b0;
        spy_grant    = 1'b0;
        cpu_ready    = 1'b0;
        spy_ack      = 1'b0;
        mem_raddr    = '0;
        mem_rden     = 1'b0;
        mem_waddr    = '0;
        mem_wren     = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            S_IDLE: begin
                cpu_ready = (starve_q < STARVE_C);
                if (cpu_ready && cpu_push && !cpu_pop) begin
                    mem_wren  = 1'b1;
                    mem_waddr = spcptr_q + PTR_ONE;
                    mem_wdata = cpu_wdata;
                    spcptr_d  = spcptr_q + PTR_ONE;
                    if (depth_q == FULL) begin
                        ovf_set = 1'b1;
                    end else begin
                        depth_d = depth_q + DEP_ONE;
                    end
                end else if (cpu_ready && cpu_pop && !cpu_push) begin
                    mem_rden  = 1'b1;
                    mem_raddr = spcptr_q;
                    state_d   = S_POP_RD;
                end else if (cpu_ready && cpu_pop && cpu_push) begin
                    mem_rden  = 1'b1;
                    mem_raddr = spcptr_q;
                    wbuf_d    = cpu_wdata;
                    state_d   = S_REPL_RD;
                end else if (spy_req) begin
                    spy_grant = 1'b1;
                    if (spy_ptr_we) begin
                        spcptr_d = spy_addr;
                        state_d  = S_SPY_DONE;
                    end else if (spy_we) begin
                        mem_wren  = 1'b1;
                        mem_waddr = spy_addr;
                        mem_wdata = spy_wdata;
                        state_d   = S_SPY_DONE;
                    end else begin
                        mem_rden  = 1'b1;
                        mem_raddr = spy_addr;
                        state_d   = S_SPY_RD;
                    end
                end
            end
            S_POP_RD: begin
                cpu_rdata_d  = mem_q;
                cpu_rvalid_d = 1'b1;
                spcptr_d     = spcptr_q - PTR_ONE;
                if (depth_q == '0) begin
                    unf_set = 1'b1;
                end else begin
                    depth_d = depth_q - DEP_ONE;
                end
                state_d = S_IDLE;
            end
            S_REPL_RD: begin
                cpu_rdata_d  = mem_q;
                cpu_rvalid_d = 1'b1;
                state_d      = S_REPL_WR;
            end
            S_REPL_WR: begin
                mem_wren  = 1'b1;
                mem_waddr = spcptr_q;
                mem_wdata = wbuf_q;
                state_d   = S_IDLE;
            end
            S_SPY_RD: begin
                spy_rdata_d = mem_q;
                state_d     = S_SPY_DONE;
            end
            S_SPY_DONE: begin
                spy_ack = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flag event in the same cycle as spy_clr leaves the flag set.
        ovf_d = ovf_set | (ovf_q & ~spy_clr);
        unf_d = unf_set | (unf_q & ~spy_clr);

        // Only cycles spent waiting count toward starvation; the cycles of
        // the spy access itself would otherwise leave a stale count behind.
        spy_busy = (state_q == S_SPY_RD) || (state_q == S_SPY_DONE);
        starve_d = starve_q;
        if (spy_grant) begin
            starve_d = '0;
        end else if (spy_req && !spy_busy && (starve_q < STARVE_C)) begin
            starve_d = starve_q + SC_ONE;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign spy_rdata  = spy_rdata_q;
    assign spcptr     = spcptr_q;
    assign depth      = depth_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;

endmodule

// File: tb/tb_spc_ctl.sv
// Self-checking bench for spc_ctl: directed vector table, hand-written
// corner sequences and a randomized run against a stack reference model.
module tb_spc_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_push = 1'b0, cpu_pop = 1'b0;
    logic [18:0] cpu_wdata = '0;
    logic        cpu_ready, cpu_rvalid;
    logic [18:0] cpu_rdata;
    logic        spy_req = 1'b0, spy_we = 1'b0, spy_ptr_we = 1'b0, spy_clr = 1'b0;
    logic [4:0]  spy_addr = '0;
    logic [18:0] spy_wdata = '0;
    logic        spy_ack;
    logic [18:0] spy_rdata;
    logic [4:0]  mem_raddr, mem_waddr;
    logic        mem_rden, mem_wren;
    logic [18:0] mem_q = '0;
    logic [18:0] mem_wdata;
    logic [4:0]  spcptr;
    logic [5:0]  depth;
    logic        ovf, unf;

    spc_ctl #(.AW(5), .DW(19), .STARVE(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_push(cpu_push), .cpu_pop(cpu_pop), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .spy_req(spy_req), .spy_we(spy_we), .spy_ptr_we(spy_ptr_we),
        .spy_clr(spy_clr), .spy_addr(spy_addr), .spy_wdata(spy_wdata),
        .spy_ack(spy_ack), .spy_rdata(spy_rdata),
        .mem_raddr(mem_raddr), .mem_rden(mem_rden), .mem_q(mem_q),
        .mem_waddr(mem_waddr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .spcptr(spcptr), .depth(depth), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Stack RAM: write port B, registered read port A; bench preload port.
    logic [18:0] ram [32];
    logic        ld_we = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [18:0] ld_data = '0;
    always @(posedge clk) begin
        if (mem_wren) ram[mem_waddr] <= mem_wdata;
        else if (ld_we) ram[ld_addr] <= ld_data;
        if (mem_rden) mem_q <= ram[mem_raddr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic        push, pop;
        logic [18:0] wd;
        logic        ready, wren;
        logic [4:0]  waddr;
        logic [18:0] wdata;
        logic        rden;
        logic [4:0]  raddr;
        logic        rvalid;
        logic [18:0] rdata;
        logic [4:0]  ptr;
        logic [5:0]  dep;
    } vec_t;

    function automatic vec_t mkv(input logic push, pop, input logic [18:0] wd,
                                 input logic ready, wren, input logic [4:0] waddr,
                                 input logic [18:0] wdata, input logic rden,
                                 input logic [4:0] raddr, input logic rvalid,
                                 input logic [18:0] rdata, input logic [4:0] ptr,
                                 input logic [5:0] dep);
        vec_t v;
        v.push = push; v.pop = pop; v.wd = wd; v.ready = ready; v.wren = wren;
        v.waddr = waddr; v.wdata = wdata; v.rden = rden; v.raddr = raddr;
        v.rvalid = rvalid; v.rdata = rdata; v.ptr = ptr; v.dep = dep;
        return v;
    endfunction

    task automatic cyc(input logic push, input logic pop, input logic [18:0] wd, input logic clr);
        @(posedge clk); #1;
        cpu_push = push; cpu_pop = pop; cpu_wdata = wd; spy_clr = clr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cpu_push = 0; cpu_pop = 0; spy_req = 0; spy_clr = 0; spy_we = 0; spy_ptr_we = 0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk(nm, {spcptr, depth, ovf, unf, cpu_rvalid, cpu_rdata, spy_ack, spy_rdata, mem_wren, mem_rden},
            55'd0);
    endtask

    // Reference model state.
    logic [18:0] ref_mem [32];
    logic [4:0]  m_ptr;
    int          m_dep;
    bit          m_ovf, m_unf;
    logic [18:0] expq [$];

    task automatic preload_rand();
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            ld_we = 1'b1; ld_addr = 5'(i); ld_data = 19'($urandom);
            ref_mem[i] = ld_data;
        end
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    vec_t vt [11];
    logic [62:0] act_v, exp_v;
    int n_acc, drop_c, ack_c, wait_c, r;
    bit spy_drop;
    logic [18:0] e;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up: preload RAM while held in reset.
        reset = 1'b0;
        preload_rand();
        #1;
        chk_reset_vals("reset_vals");
        @(negedge clk);
        reset = 1'b1;

        // Table: 3 pushes, 2 pops, replace at depth 1.
        vt[0]  = mkv(1,0,19'h00001, 1,1,5'd1,19'h00001, 0,5'd0, 0,19'h0,     5'd0,6'd0);
        vt[1]  = mkv(1,0,19'h00002, 1,1,5'd2,19'h00002, 0,5'd0, 0,19'h0,     5'd1,6'd1);
        vt[2]  = mkv(1,0,19'h00003, 1,1,5'd3,19'h00003, 0,5'd0, 0,19'h0,     5'd2,6'd2);
        vt[3]  = mkv(0,1,19'h0,     1,0,5'd0,19'h0,     1,5'd3, 0,19'h0,     5'd3,6'd3);
        vt[4]  = mkv(0,1,19'h0,     0,0,5'd0,19'h0,     0,5'd0, 0,19'h0,     5'd3,6'd3);
        vt[5]  = mkv(0,1,19'h0,     1,0,5'd0,19'h0,     1,5'd2, 1,19'h00003, 5'd2,6'd2);
        vt[6]  = mkv(1,0,19'h00055, 0,0,5'd0,19'h0,     0,5'd0, 0,19'h00003, 5'd2,6'd2);
        vt[7]  = mkv(1,1,19'h7FFFF, 1,0,5'd0,19'h0,     1,5'd1, 1,19'h00002, 5'd1,6'd1);
        vt[8]  = mkv(0,0,19'h0,     0,0,5'd0,19'h0,     0,5'd0, 0,19'h00002, 5'd1,6'd1);
        vt[9]  = mkv(0,0,19'h0,     0,1,5'd1,19'h7FFFF, 0,5'd0, 1,19'h00001, 5'd1,6'd1);
        vt[10] = mkv(0,0,19'h0,     1,0,5'd0,19'h0,     0,5'd0, 0,19'h00001, 5'd1,6'd1);
        for (int i = 0; i < 11; i++) begin
            cyc(vt[i].push, vt[i].pop, vt[i].wd, 1'b0);
            act_v = {cpu_ready, mem_wren, mem_wren ? mem_waddr : 5'd0, mem_wren ? mem_wdata : 19'd0,
                     mem_rden, mem_rden ? mem_raddr : 5'd0, cpu_rvalid, cpu_rdata, spcptr, depth};
            exp_v = {vt[i].ready, vt[i].wren, vt[i].waddr, vt[i].wdata, vt[i].rden, vt[i].raddr,
                     vt[i].rvalid, vt[i].rdata, vt[i].ptr, vt[i].dep};
            chk($sformatf("vec%0d", i), 64'(act_v), 64'(exp_v));
        end
        chk("repl_mem1", 64'(ram[1]), 64'h7FFFF);

        // 33 pushes from reset: ovf on the 33rd, pointer wraps to 1.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 33; i++) begin
            cyc(1, 0, 19'(i), 1'b0);
            if (cpu_ready) n_acc++;
            if (i == 32) chk("pre_ovf", {ovf, depth}, {1'b0, 6'd32});
        end
        chk("push_rate", 64'(n_acc), 64'd33);
        cyc(0, 0, 19'h0, 1'b0);
        chk("ovf_33", {ovf, unf, depth, spcptr}, {1'b1, 1'b0, 6'd32, 5'd1});

        // Pop from reset: unf, pointer wraps to 31; then fill to ovf too.
        do_reset();
        cyc(0, 1, 19'h0, 1'b0);
        cyc(0, 0, 19'h0, 1'b0);
        cyc(0, 0, 19'h0, 1'b0);
        chk("unf_pop", {unf, ovf, spcptr, depth, cpu_rvalid}, {1'b1, 1'b0, 5'd31, 6'd0, 1'b1});
        for (int i = 0; i < 33; i++) cyc(1, 0, 19'(i), 1'b0);
        cyc(0, 0, 19'h0, 1'b0);
        chk("both_flags", {ovf, unf, depth, spcptr}, {1'b1, 1'b1, 6'd32, 5'd0});
        cyc(1, 0, 19'h1234, 1'b1);
        cyc(0, 0, 19'h0, 1'b0);
        chk("set_wins", {ovf, unf, depth, spcptr}, {1'b1, 1'b0, 6'd32, 5'd1});
        cyc(0, 0, 19'h0, 1'b1);
        cyc(0, 0, 19'h0, 1'b0);
        chk("clr_flags", {ovf, unf}, 2'b00);

        // Starvation: continuous pushes while a spy read of addr 5 waits.
        do_reset();
        n_acc = 0; drop_c = -1; ack_c = -1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin spy_req = 1; spy_we = 0; spy_ptr_we = 0; spy_addr = 5'd5; end
            if (ack_c >= 0) spy_req = 0;
            cpu_push = 1; cpu_pop = 0; cpu_wdata = 19'(32'h100 + c);
            @(negedge clk);
            if (ack_c < 0) begin
                if (cpu_ready) n_acc++;
                else if (drop_c < 0) drop_c = c;
            end
            if (spy_ack) begin
                chk("starve_rdata", 64'(spy_rdata), 64'h104);
                ack_c = c;
            end else if (ack_c >= 0 && c > ack_c) begin
                chk("starve_resume", {cpu_ready, spcptr}, {1'b1, 5'd8});
                break;
            end
        end
        chk("starve_drop", 64'(drop_c), 64'd8);
        chk("starve_acc", 64'(n_acc), 64'd8);
        chk("starve_ack", 64'(ack_c >= 0), 64'd1);
        cyc(0, 0, 19'h0, 1'b0);

        // Reset asserted in the middle of a replace.
        do_reset();
        cyc(1, 0, 19'h0AAAA, 1'b0);
        cyc(1, 1, 19'h15555, 1'b0);
        @(posedge clk); #1;
        cpu_push = 0; cpu_pop = 0;
        reset = 1'b0;
        #1;
        chk_reset_vals("mid_repl_reset");
        @(negedge clk);
        chk("mid_repl_nowr", {mem_wren, mem_rden, cpu_rvalid}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 19'h0, 1'b0);
        cyc(0, 0, 19'h0, 1'b0);
        chk("mid_repl_mem", {64'(ram[1])}, 64'h0AAAA);
        chk("mid_repl_post", {spcptr, depth, cpu_rvalid, cpu_rdata}, 31'd0);

        // Randomized run against the stack model.
        @(negedge clk);
        reset = 1'b0; cpu_push = 0; cpu_pop = 0; spy_req = 0; spy_clr = 0;
        preload_rand();
        @(negedge clk);
        reset = 1'b1;
        m_ptr = '0; m_dep = 0; m_ovf = 0; m_unf = 0; expq.delete();
        spy_drop = 0; wait_c = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (spy_drop) begin
                spy_req = 0; spy_drop = 0;
            end else if (!spy_req && c < 2950 && $urandom_range(0, 5) == 0) begin
                spy_req = 1;
                spy_ptr_we = ($urandom_range(0, 5) == 0);
                spy_we = 1'($urandom);
                spy_addr = 5'($urandom);
                spy_wdata = 19'($urandom);
                wait_c = 0;
            end
            r = (c < 2950) ? int'($urandom_range(0, 9)) : 9;
            cpu_push = (r < 4) || (r == 7);
            cpu_pop = (r >= 4 && r <= 7);
            cpu_wdata = 19'($urandom);
            spy_clr = cpu_ready && ($urandom_range(0, 24) == 0);
            @(negedge clk);
            if (cpu_ready)
                chk("rnd_state", {spcptr, depth, ovf, unf}, {m_ptr, 6'(m_dep), m_ovf, m_unf});
            if (spy_clr) begin m_ovf = 0; m_unf = 0; end
            if (cpu_ready && cpu_push && !cpu_pop) begin
                m_ptr = m_ptr + 5'd1;
                ref_mem[m_ptr] = cpu_wdata;
                if (m_dep == 32) m_ovf = 1; else m_dep++;
            end else if (cpu_ready && cpu_pop && !cpu_push) begin
                expq.push_back(ref_mem[m_ptr]);
                m_ptr = m_ptr - 5'd1;
                if (m_dep == 0) m_unf = 1; else m_dep--;
            end else if (cpu_ready && cpu_pop && cpu_push) begin
                expq.push_back(ref_mem[m_ptr]);
                ref_mem[m_ptr] = cpu_wdata;
            end
            if (mem_wren && mem_rden)
                chk("rnd_port_clash", 64'(mem_waddr != mem_raddr), 64'd1);
            if (cpu_rvalid) begin
                if (expq.size() == 0) begin
                    chk("rnd_rvalid_extra", 64'(cpu_rvalid), 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("rnd_rdata", 64'(cpu_rdata), 64'(e));
                end
            end
            if (spy_ack) begin
                if (spy_ptr_we) m_ptr = spy_addr;
                else if (spy_we) ref_mem[spy_addr] = spy_wdata;
                else chk("rnd_spy_rdata", 64'(spy_rdata), 64'(ref_mem[spy_addr]));
                chk("rnd_spy_wait", 64'(wait_c <= 15), 64'd1);
                spy_drop = 1;
            end else if (spy_req && !spy_drop) begin
                wait_c++;
                if (wait_c == 40) begin
                    chk("rnd_spy_timeout", 64'(wait_c), 64'd15);
                    spy_drop = 1;
                end
            end
        end
        chk("rnd_queue_empty", 64'(expq.size()), 64'd0);
        chk("rnd_final", {spcptr, depth, ovf, unf}, {m_ptr, 6'(m_dep), m_ovf, m_unf});
        n_acc = 0;
        for (int i = 0; i < 32; i++) if (ram[i] !== ref_mem[i]) n_acc++;
        chk("rnd_ram_image", 64'(n_acc), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spc_ctl.md
Name: spc_ctl

Overview:
- Sequencer and arbiter in front of the 32x19 SPC stack RAM (dual-port: read port A, write port B, registered read data, 1-cycle read latency).
- Owns the stack pointer, and turns CPU push/pop/replace requests into RAM cycles.
- Shares the RAM with the spy/debug bus, which reads and writes arbitrary entries and loads the pointer.
- Tracks stack depth and raises sticky overflow/underflow flags.

Parameters:
AW, 5, address/pointer width (stack depth 2**AW)
DW, 19, entry width
STARVE, 8, cycles a spy request may wait before the CPU is stalled for one slot

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cpu_push  in  1  push cpu_wdata (sampled when cpu_ready)
cpu_pop  in  1  pop top entry (sampled when cpu_ready); with cpu_push = replace top
cpu_wdata  in  DW  push/replace data
cpu_ready  out  1  CPU op accepted this cycle
cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse)
cpu_rdata  out  DW  popped entry
spy_req  in  1  spy access request, held until spy_ack
spy_we  in  1  1=write entry, 0=read entry
spy_ptr_we  in  1  load pointer from spy_addr (overrides spy_we)
spy_clr  in  1  clear sticky flags (single cycle, any time)
spy_addr  in  AW  entry address / new pointer
spy_wdata  in  DW  spy write data
spy_ack  out  1  one-cycle completion pulse
spy_rdata  out  DW  spy read data, valid with spy_ack
mem_raddr  out  AW  RAM port A address
mem_rden  out  1  RAM port A read enable
mem_q  in  DW  RAM port A data (valid the cycle after mem_rden)
mem_waddr  out  AW  RAM port B address
mem_wren  out  1  RAM port B write enable
mem_wdata  out  DW  RAM port B data
spcptr  out  AW  current stack pointer (top entry)
depth  out  AW+1  valid entries, 0..2**AW
ovf  out  1  sticky overflow
unf  out  1  sticky underflow

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE; spcptr=0, depth=0, ovf=unf=0; all strobes 0; cpu_rdata=spy_rdata=0; starve counter=0.
- FSM states: IDLE, POP_RD, REPL_RD, REPL_WR, SPY_RD, SPY_DONE.
- cpu_ready=1 only in IDLE, and only when the starve counter is below STARVE.
- Push (IDLE, push only):
  - Same cycle: mem_wren=1, mem_waddr=spcptr+1, mem_wdata=cpu_wdata.
  - spcptr increments at the next edge. Stay in IDLE, so back-to-back pushes run at 1 per cycle.
- Pop (IDLE, pop only):
  - Same cycle: mem_rden=1, mem_raddr=spcptr; go to POP_RD.
  - POP_RD: cpu_rdata<=mem_q and cpu_rvalid=1 next cycle; spcptr decrements on the POP_RD edge; return to IDLE. Pop throughput is 1 per 2 cycles.
- Replace (push and pop together):
  - IDLE: read spcptr; latch cpu_wdata.
  - REPL_RD: capture old top into cpu_rdata.
  - REPL_WR: write latched data to spcptr; cpu_rvalid pulses in REPL_WR.
  - spcptr and depth are unchanged.
- Pointer arithmetic is modulo 2**AW, so wrap-around is silent.
- Depth counter:
  - Push with depth=2**AW sets ovf; depth stays saturated.
  - Pop with depth=0 sets unf; depth stays 0.
  - Otherwise depth follows push (+1) and pop (-1).
  - Replace never changes depth or the flags.
- Spy grant:
  - Granted in IDLE when no CPU op is accepted that cycle, i.e. the CPU has priority.
  - A starve counter counts cycles with spy_req=1 and no grant. At STARVE it forces cpu_ready=0, which guarantees a grant in the next IDLE cycle. The counter clears on grant.
- Spy operations:
  - Pointer load: spcptr<=spy_addr; depth and flags unchanged; SPY_DONE next, spy_ack pulses.
  - Write: mem_wren, mem_waddr=spy_addr; then SPY_DONE/ack.
  - Read: mem_rden, mem_raddr=spy_addr; SPY_RD captures spy_rdata; then SPY_DONE/ack.
  - SPY_DONE always returns to IDLE. A requester must drop spy_req after ack or it is re-served.
- mem_wren and mem_rden never assert for the same address in the same cycle.
- spy_clr coinciding with a flag-setting event: the set wins.

Test Plan:
- Reset, then 3 pushes of 0x00001, 0x00002, 0x00003 on consecutive cycles -> writes to addresses 1, 2, 3; spcptr=3; depth=3; cpu_ready high throughout.
- Pop twice -> cpu_rdata 0x00003 then 0x00002, each with a 1-cycle rvalid; spcptr=1; depth=1; cpu_ready low in each POP_RD.
- Replace with 0x7FFFF at depth=1 -> cpu_rdata=0x00001; mem[1]=0x7FFFF; spcptr=1; depth=1.
- 33 pushes from reset -> ovf=1 on the 33rd push; depth=32; spcptr wraps to 1. Pop from reset -> unf=1, spcptr=31. spy_clr -> both flags 0.
- CPU pushes every cycle while spy read of addr 5 is pending -> cpu_ready drops after 8 waiting cycles; spy_ack with mem[5]; pushes resume.
- Assert reset mid-REPL_RD -> FSM IDLE, no write issued, all outputs return to reset values.
